// File: rtl/invader_motion.sv
// Invader sprite motion: frame-paced left/right sweep with step-down, landing and kill handling.
// Optional INVADER_SPEEDUP_EN: each step-down shortens the frames-per-move reload (minimum 1).
module invader_motion #(
   parameter int RECT_WIDTH = 32,
   parameter int X_START    = 0,
   parameter int Y_START    = 64,
   parameter int X_MAX      = 800 - RECT_WIDTH,
   parameter int Y_LIMIT    = 536,
   parameter int STEP_X     = 4,
   parameter int STEP_Y     = 16,
   parameter int FRAME_DIV  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        start,
   input  logic        hit,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        enabled,
   output logic        landed
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RIGHT  = 3'd1,
      LEFT   = 3'd2,
      DOWN   = 3'd3,
      LANDED = 3'd4,
      DEAD   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic        vblnk_q;
   logic        armed;
   logic        dir_left;
   logic [3:0]  cnt;
   logic [3:0]  reload;
   logic        moving;
   logic        tick;
   logic        move_tick;
   logic [12:0] x_add, x_sub, y_add;
   logic        at_right, at_left, y_land;

   assign moving    = (state == RIGHT) || (state == LEFT) || (state == DOWN);
   // armed keeps a vblnk that is already high at reset release from looking like an edge
   assign tick      = armed && vblnk && !vblnk_q;
   assign move_tick = moving && tick && (cnt == reload - 4'd1);

   assign x_add    = {1'b0, xpos} + 13'(STEP_X);
   assign x_sub    = {1'b0, xpos} - 13'(STEP_X);
   assign y_add    = {1'b0, ypos} + 13'(STEP_Y);
   assign at_right = x_add >= 13'(X_MAX);
   assign at_left  = {1'b0, xpos} <= 13'(STEP_X);
   assign y_land   = y_add >= 13'(Y_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, LANDED, DEAD: if (start) state_nxt = RIGHT;
         RIGHT: begin
            if (hit)                        state_nxt = DEAD;
            else if (move_tick && at_right) state_nxt = DOWN;
         end
         LEFT: begin
            if (hit)                       state_nxt = DEAD;
            else if (move_tick && at_left) state_nxt = DOWN;
         end
         DOWN: begin
            if (hit)            state_nxt = DEAD;
            else if (move_tick) state_nxt = y_land ? LANDED : (dir_left ? LEFT : RIGHT);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      enabled = moving;
      landed  = (state == LANDED);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         xpos     <= 12'(X_START);
         ypos     <= 12'(Y_START);
         dir_left <= 1'b0;
         cnt      <= 4'd0;
         reload   <= 4'(FRAME_DIV);
         vblnk_q  <= 1'b0;
         armed    <= 1'b0;
      end else begin
         vblnk_q <= vblnk;
         armed   <= 1'b1;
         if (start && !moving) begin
            xpos     <= 12'(X_START);
            ypos     <= 12'(Y_START);
            dir_left <= 1'b0;
            cnt      <= 4'd0;
            reload   <= 4'(FRAME_DIV);
         end else if (moving && !hit && tick) begin
            if (move_tick) begin
               cnt <= 4'd0;
               case (state)
                  RIGHT: begin
                     xpos <= at_right ? 12'(X_MAX) : x_add[11:0];
                     if (at_right) dir_left <= 1'b1;
                  end
                  LEFT: begin
                     xpos <= at_left ? 12'd0 : x_sub[11:0];
                     if (at_left) dir_left <= 1'b0;
                  end
                  DOWN: begin
                     ypos <= y_add[11:0];
`ifdef INVADER_SPEEDUP_EN
                     if (reload > 4'd1) reload <= reload - 4'd1;
`else
                     reload <= 4'(FRAME_DIV);
`endif
                  end
                  default: cnt <= 4'd0;
               endcase
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_invader_motion.sv
// Directed bench for invader_motion: four instances with different start/limit parameters.
module tb_invader_motion;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic vblnk = 1'b0;
   logic start = 1'b0;
   logic hit = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [11:0] xa, ya, xb, yb, xc, yc, xd, yd;
   logic        ena, lda, enb, ldb, enc, ldc, end_, ldd;

   always #5 clk = ~clk;

   invader_motion u_a (.clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .hit(hit),
                       .xpos(xa), .ypos(ya), .enabled(ena), .landed(lda));
   invader_motion #(.X_START(766)) u_b (.clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .hit(hit),
                       .xpos(xb), .ypos(yb), .enabled(enb), .landed(ldb));
   invader_motion #(.X_START(766), .Y_START(528)) u_c (.clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .hit(hit),
                       .xpos(xc), .ypos(yc), .enabled(enc), .landed(ldc));
   invader_motion #(.X_MAX(10)) u_d (.clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .hit(hit),
                       .xpos(xd), .ypos(yd), .enabled(end_), .landed(ldd));

   task automatic do_reset();
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk) vblnk = 1'b1;
      repeat (2) @(negedge clk);
      vblnk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (xa !== 12'd0)  begin errors++; $display("FAIL reset_x: got %0d want 0", xa); end
      checks++; if (ya !== 12'd64) begin errors++; $display("FAIL reset_y: got %0d want 64", ya); end
      checks++; if (ena !== 1'b0)  begin errors++; $display("FAIL reset_en: got %0b want 0", ena); end
      checks++; if (lda !== 1'b0)  begin errors++; $display("FAIL reset_landed: got %0b want 0", lda); end
      checks++; if (xb !== 12'd766) begin errors++; $display("FAIL reset_xb: got %0d want 766", xb); end
      @(negedge clk) hit = 1'b1;
      @(negedge clk) hit = 1'b0;
      frames(4);
      checks++; if (xa !== 12'd0 || ena !== 1'b0) begin errors++; $display("FAIL idle_hold: got x=%0d en=%0b want x=0 en=0", xa, ena); end
      pulse_start();
      checks++; if (ena !== 1'b1) begin errors++; $display("FAIL idle_hit_ignored: got en=%0b want 1", ena); end
   endtask

   task automatic test_motion();
      do_reset();
      pulse_start();
      checks++; if (ena !== 1'b1 || xa !== 12'd0) begin errors++; $display("FAIL start_en: got en=%0b x=%0d want en=1 x=0", ena, xa); end
      frame();
      checks++; if (xa !== 12'd0) begin errors++; $display("FAIL one_frame_hold: got %0d want 0", xa); end
      frames(3);
      checks++; if (xa !== 12'd8 || ya !== 12'd64 || ena !== 1'b1) begin errors++; $display("FAIL two_moves: got x=%0d y=%0d en=%0b want x=8 y=64 en=1", xa, ya, ena); end
      pulse_start();
      frame();
      checks++; if (xa !== 12'd8) begin errors++; $display("FAIL start_ignored_moving: got %0d want 8", xa); end
   endtask

   task automatic test_right_edge();
      do_reset();
      pulse_start();
      frames(2);
      checks++; if (xb !== 12'd768 || yb !== 12'd64) begin errors++; $display("FAIL right_clamp: got x=%0d y=%0d want x=768 y=64", xb, yb); end
      frames(2);
      checks++; if (yb !== 12'd80 || xb !== 12'd768) begin errors++; $display("FAIL step_down: got x=%0d y=%0d want x=768 y=80", xb, yb); end
      frame();
`ifdef INVADER_SPEEDUP_EN
      checks++; if (xb !== 12'd764) begin errors++; $display("FAIL speedup_first: got %0d want 764", xb); end
      frame();
      checks++; if (xb !== 12'd760) begin errors++; $display("FAIL speedup_second: got %0d want 760", xb); end
`else
      checks++; if (xb !== 12'd768) begin errors++; $display("FAIL left_wait: got %0d want 768", xb); end
      frame();
      checks++; if (xb !== 12'd764) begin errors++; $display("FAIL left_move: got %0d want 764", xb); end
`endif
   endtask

   task automatic test_left_edge();
      int fpm;
      fpm = 2;
      do_reset();
      pulse_start();
      frames(3 * fpm);
      checks++; if (xd !== 12'd10) begin errors++; $display("FAIL small_right_clamp: got %0d want 10", xd); end
      frames(fpm);
`ifdef INVADER_SPEEDUP_EN
      fpm = 1;
`endif
      checks++; if (yd !== 12'd80) begin errors++; $display("FAIL small_step_down: got %0d want 80", yd); end
      frames(2 * fpm);
      checks++; if (xd !== 12'd2) begin errors++; $display("FAIL left_to_2: got %0d want 2", xd); end
      frames(fpm);
      checks++; if (xd !== 12'd0 || end_ !== 1'b1) begin errors++; $display("FAIL left_clamp: got x=%0d en=%0b want x=0 en=1", xd, end_); end
      frames(fpm);
      checks++; if (yd !== 12'd96 || xd !== 12'd0) begin errors++; $display("FAIL left_step_down: got x=%0d y=%0d want x=0 y=96", xd, yd); end
      frames(fpm);
      checks++; if (xd !== 12'd4) begin errors++; $display("FAIL back_right: got %0d want 4", xd); end
   endtask

   task automatic test_hit();
      do_reset();
      pulse_start();
      frames(5);
      @(negedge clk) begin vblnk = 1'b1; hit = 1'b1; end
      @(negedge clk) hit = 1'b0;
      checks++; if (xa !== 12'd8 || ena !== 1'b0) begin errors++; $display("FAIL hit_priority: got x=%0d en=%0b want x=8 en=0", xa, ena); end
      @(negedge clk) vblnk = 1'b0;
      frames(4);
      checks++; if (xa !== 12'd8 || ya !== 12'd64 || ena !== 1'b0) begin errors++; $display("FAIL dead_hold: got x=%0d y=%0d en=%0b want x=8 y=64 en=0", xa, ya, ena); end
      pulse_start();
      checks++; if (xa !== 12'd0 || ya !== 12'd64 || ena !== 1'b1) begin errors++; $display("FAIL restart: got x=%0d y=%0d en=%0b want x=0 y=64 en=1", xa, ya, ena); end
   endtask

   task automatic test_landed();
      do_reset();
      pulse_start();
      frames(4);
      checks++; if (yc !== 12'd544 || ldc !== 1'b1 || enc !== 1'b0) begin errors++; $display("FAIL land: got y=%0d landed=%0b en=%0b want y=544 landed=1 en=0", yc, ldc, enc); end
      @(negedge clk) hit = 1'b1;
      @(negedge clk) hit = 1'b0;
      frames(3);
      checks++; if (ldc !== 1'b1 || yc !== 12'd544) begin errors++; $display("FAIL landed_hold: got landed=%0b y=%0d want landed=1 y=544", ldc, yc); end
      pulse_start();
      checks++; if (ldc !== 1'b0 || xc !== 12'd766 || yc !== 12'd528 || enc !== 1'b1) begin errors++; $display("FAIL land_restart: got landed=%0b x=%0d y=%0d en=%0b want 0 766 528 1", ldc, xc, yc, enc); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      pulse_start();
      frames(2);
      @(negedge clk) begin rst = 1'b0; vblnk = 1'b1; end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (xa !== 12'd0 || ya !== 12'd64 || ena !== 1'b0) begin errors++; $display("FAIL mid_reset: got x=%0d y=%0d en=%0b want x=0 y=64 en=0", xa, ya, ena); end
      pulse_start();
      @(negedge clk) vblnk = 1'b0;
      frames(1);
      checks++; if (xa !== 12'd0) begin errors++; $display("FAIL mid_reset_count: got %0d want 0", xa); end
   endtask

   initial begin
      test_reset();
      test_motion();
      test_right_edge();
      test_left_edge();
      test_hit();
      test_landed();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/invader_motion.md
INVADER_MOTION -- requirements
Module: invader_motion

Interface
REQ-001 SHALL have parameter RECT_WIDTH, default 32: sprite width in pixels, matching the downstream rectangle drawer.
REQ-002 SHALL have parameter X_START, default 0: x position after start.
REQ-003 SHALL have parameter Y_START, default 64: y position after start.
REQ-004 SHALL have parameter X_MAX, default 768: largest legal xpos (800 - RECT_WIDTH).
REQ-005 SHALL have parameter Y_LIMIT, default 536: ypos at or beyond which the sprite has landed.
REQ-006 SHALL have parameter STEP_X, default 4: horizontal pixels per move.
REQ-007 SHALL have parameter STEP_Y, default 16: vertical pixels per step-down.
REQ-008 SHALL have parameter FRAME_DIV, default 2: number of frames per move, 1..15.
REQ-009 SHALL have port clk, input, 1 bit: pixel clock, the only clock.
REQ-010 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-011 SHALL have port vblnk, input, 1 bit: vertical blank from the timing chain.
REQ-012 SHALL have port start, input, 1 bit: level-sampled start/restart request.
REQ-013 SHALL have port hit, input, 1 bit: sprite destroyed.
REQ-014 SHALL have port xpos, output, 12 bits: sprite left edge, drives the drawer's xpos.
REQ-015 SHALL have port ypos, output, 12 bits: sprite top edge, drives the drawer's ypos.
REQ-016 SHALL have port enabled, output, 1 bit: sprite visible, drives the drawer's enabled.
REQ-017 SHALL have port landed, output, 1 bit: sprite reached Y_LIMIT.

Function
REQ-018 SHALL register vblnk once and generate a one-cycle frame tick on the cycle where vblnk is 1 and the registered vblnk is 0.
REQ-019 SHALL use a 4-bit frame counter, cleared on start, that increments on each tick in a moving state; a tick with counter = reload-1 is a move tick and clears the counter.
REQ-020 SHALL implement states IDLE, RIGHT, LEFT, DOWN, LANDED and DEAD; enabled = 1 exactly in RIGHT, LEFT and DOWN.
REQ-021 SHALL, on start in IDLE, LANDED or DEAD, load xpos=X_START and ypos=Y_START, clear landed and enter RIGHT on the next clk edge; start SHALL be ignored in the other states.
REQ-022 SHALL, in RIGHT on a move tick: if xpos+STEP_X >= X_MAX, set xpos=X_MAX and enter DOWN with next direction LEFT; otherwise xpos += STEP_X.
REQ-023 SHALL, in LEFT on a move tick: if xpos <= STEP_X, set xpos=0 and enter DOWN with next direction RIGHT; otherwise xpos -= STEP_X (no unsigned underflow).
REQ-024 SHALL, in DOWN on the next move tick, apply ypos += STEP_Y; if the new ypos >= Y_LIMIT, enter LANDED and set landed=1, otherwise enter the stored next direction.
REQ-025 SHALL perform all position arithmetic in 13 bits before writing the 12-bit result, so no wrap-around is possible.
REQ-026 SHALL update xpos, ypos and enabled only on the clk edge ending a move-tick cycle, so outputs change during vblnk and stay stable across visible lines.
REQ-027 SHALL, on hit=1 in RIGHT, LEFT or DOWN, enter DEAD on the next edge, taking priority over a coincident move tick; xpos and ypos SHALL hold.
REQ-028 SHALL ignore hit in IDLE, LANDED and DEAD.
REQ-029 SHALL keep landed=1 in LANDED until the next start or reset.

Reset
REQ-030 SHALL, with rst=0 at a clk edge, set state=IDLE, xpos=X_START, ypos=Y_START, enabled=0, landed=0, the frame counter to 0, the registered vblnk to 0, and the reload to FRAME_DIV.
REQ-031 SHALL abort any in-progress motion on a mid-operation reset, with no tick produced in the first cycle after reset release.

Configuration
REQ-032 SHALL, with INVADER_SPEEDUP_EN defined, decrement the frame-counter reload by 1 (minimum 1) on every DOWN exit and restore it to FRAME_DIV on start.
REQ-033 SHALL, without INVADER_SPEEDUP_EN, hold the reload constant at FRAME_DIV.

Verification
REQ-034 SHALL verify: rst=0 for 3 clk, then release -> xpos=0, ypos=64, enabled=0, landed=0, and vblnk pulses cause no movement.
REQ-035 SHALL verify: start pulse, then 4 vblnk rising edges -> enabled=1, xpos=8 (2 moves at FRAME_DIV=2), ypos=64.
REQ-036 SHALL verify: with xpos forced to 766 via X_START=766 in RIGHT, one move tick -> xpos=768 and state DOWN; the next move tick -> ypos=80 and direction LEFT.
REQ-037 SHALL verify: in LEFT at xpos=2, a move tick -> xpos=0 (no wrap to 4094), then DOWN, then RIGHT.
REQ-038 SHALL verify: hit=1 in the same cycle as a move tick -> xpos unchanged, enabled=0 next cycle; a later start -> xpos=0, ypos=64, enabled=1.
REQ-039 SHALL verify: with Y_START=528 at a step-down -> ypos=544, landed=1, enabled=0; with INVADER_SPEEDUP_EN defined, after one DOWN exit moves occur every frame.
